// File: rtl/reg_bank8_pkg.sv
// ---------------------------------------------------------------------------
// reg_bank8_pkg
// Shared definitions for the eight-register bank: default data width,
// register count, register-index constants R_A..R_H and the FSM encoding.
// ---------------------------------------------------------------------------
package reg_bank8_pkg;

   localparam int WIDTH_DEF = 8;
   localparam int NREG_DEF  = 8;

   localparam logic [2:0] R_A = 3'd0;
   localparam logic [2:0] R_B = 3'd1;
   localparam logic [2:0] R_C = 3'd2;
   localparam logic [2:0] R_D = 3'd3;
   localparam logic [2:0] R_E = 3'd4;
   localparam logic [2:0] R_F = 3'd5;
   localparam logic [2:0] R_G = 3'd6;
   localparam logic [2:0] R_H = 3'd7;

   typedef enum logic {
      IDLE   = 1'b0,
      MOV_WR = 1'b1
   } state_e;

endpackage

// File: rtl/reg_bank8_if.sv
// ---------------------------------------------------------------------------
// reg_bank8_if
// Bundles the request inputs and register/flag outputs of reg_bank8.
//   WE/INC/MOV  : operation requests (priority MOV > INC > WE)
//   WADDR/WDATA : target and data for WE/INC
//   SRC/DST     : MOV source and destination
//   RSEL        : read select, echoed registered on S1..S3
//   A..H        : register contents 0..7
//   S1..S3      : registered RSEL (S1 = MSB)
//   BUSY        : MOV in progress
//   CARRY       : wrap flag of the last accepted INC
// master = request side, slave = reg_bank8.
// ---------------------------------------------------------------------------
interface reg_bank8_if #(
   parameter int WIDTH = reg_bank8_pkg::WIDTH_DEF
) ();

   logic             WE;
   logic             INC;
   logic             MOV;
   logic [2:0]       WADDR;
   logic [WIDTH-1:0] WDATA;
   logic [2:0]       SRC;
   logic [2:0]       DST;
   logic [2:0]       RSEL;
   logic [WIDTH-1:0] A, B, C, D, E, F, G, H;
   logic             S1, S2, S3;
   logic             BUSY;
   logic             CARRY;

   modport master (
      output WE, INC, MOV, WADDR, WDATA, SRC, DST, RSEL,
      input  A, B, C, D, E, F, G, H, S1, S2, S3, BUSY, CARRY
   );

   modport slave (
      input  WE, INC, MOV, WADDR, WDATA, SRC, DST, RSEL,
      output A, B, C, D, E, F, G, H, S1, S2, S3, BUSY, CARRY
   );

endinterface

// File: rtl/reg_bank8.sv
// ---------------------------------------------------------------------------
// reg_bank8
// Eight-entry register bank with write, increment and two-cycle move.
// Ports:
//   CLK   : rising-edge clock
//   RST_N : asynchronous active-low reset, clears all state
//   bus   : reg_bank8_if slave modport (requests in, registers/flags out)
// Requests are only sampled in IDLE; a MOV latches source data and
// destination on its first edge and writes on the second, so any request
// presented while BUSY is dropped.
// ---------------------------------------------------------------------------
module reg_bank8
   import reg_bank8_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int NREG  = NREG_DEF
) (
   input  logic     CLK,
   input  logic     RST_N,
   reg_bank8_if.slave bus
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] regs_q [NREG];
   logic [WIDTH-1:0] regs_d [NREG];
   logic [WIDTH-1:0] tmp_q, tmp_d;
   logic [2:0]       dst_q, dst_d;
   logic             carry_q, carry_d;
   logic [2:0]       sel_q;
   logic             busy;

   // ---- FSM: state register ----
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // ---- FSM: next state ----
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.MOV) state_d = MOV_WR;
         MOV_WR:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---- FSM: outputs ----
   always_comb begin
      busy = (state_q == MOV_WR);
   end

   // ---- Datapath next-state ----
   always_comb begin
      regs_d  = regs_q;
      tmp_d   = tmp_q;
      dst_d   = dst_q;
      carry_d = carry_q;
      if (state_q == IDLE) begin
         if (bus.MOV) begin
            tmp_d = regs_q[bus.SRC];
            dst_d = bus.DST;
         end else if (bus.INC) begin
            regs_d[bus.WADDR] = regs_q[bus.WADDR] + ONE;
            carry_d           = &regs_q[bus.WADDR];
         end else if (bus.WE) begin
            regs_d[bus.WADDR] = bus.WDATA;
         end
      end else begin
         // Second MOV edge: only the latched copy is used, live SRC/DST ignored.
         regs_d[dst_q] = tmp_q;
      end
   end

   // ---- Datapath registers ----
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
         tmp_q   <= '0;
         dst_q   <= '0;
         carry_q <= 1'b0;
         sel_q   <= '0;
      end else begin
         regs_q  <= regs_d;
         tmp_q   <= tmp_d;
         dst_q   <= dst_d;
         carry_q <= carry_d;
         sel_q   <= bus.RSEL;
      end
   end

   assign bus.A     = regs_q[R_A];
   assign bus.B     = regs_q[R_B];
   assign bus.C     = regs_q[R_C];
   assign bus.D     = regs_q[R_D];
   assign bus.E     = regs_q[R_E];
   assign bus.F     = regs_q[R_F];
   assign bus.G     = regs_q[R_G];
   assign bus.H     = regs_q[R_H];
   assign bus.S1    = sel_q[2];
   assign bus.S2    = sel_q[1];
   assign bus.S3    = sel_q[0];
   assign bus.BUSY  = busy;
   assign bus.CARRY = carry_q;

endmodule

// File: tb/tb_reg_bank8.sv
module tb_reg_bank8;

   localparam int W = 8;

   typedef struct {
      int         idx;   // 0..7 register, 8 CARRY, 9 BUSY, 10 {S1,S2,S3}
      logic [W-1:0] val;
   } exp_t;

   logic CLK;
   logic RST_N;
   reg_bank8_if #(.WIDTH(W)) bus ();

   reg_bank8 #(.WIDTH(W), .NREG(8)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus)
   );

   exp_t          sb[$];
   exp_t          e;
   logic [W-1:0]  m_reg [8];
   logic          m_carry;
   int            checks = 0;
   int            errors = 0;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   function automatic logic [W-1:0] dut_val(input int idx);
      case (idx)
         0: return bus.A;
         1: return bus.B;
         2: return bus.C;
         3: return bus.D;
         4: return bus.E;
         5: return bus.F;
         6: return bus.G;
         7: return bus.H;
         8: return {{(W-1){1'b0}}, bus.CARRY};
         9: return {{(W-1){1'b0}}, bus.BUSY};
         default: return {{(W-3){1'b0}}, bus.S1, bus.S2, bus.S3};
      endcase
   endfunction

   function automatic string idx_name(input int idx);
      case (idx)
         8: return "CARRY";
         9: return "BUSY";
         10: return "SEL";
         default: return $sformatf("reg%0d", idx);
      endcase
   endfunction

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic push(input int idx, input logic [W-1:0] v);
      exp_t x;
      x.idx = idx;
      x.val = v;
      sb.push_back(x);
   endtask

   // Expected registers, CARRY and BUSY taken from the bench model.
   task automatic push_model(input logic busy_exp);
      for (int i = 0; i < 8; i++) push(i, m_reg[i]);
      push(8, {{(W-1){1'b0}}, m_carry});
      push(9, {{(W-1){1'b0}}, busy_exp});
   endtask

   task automatic idle_inputs();
      bus.WE = 0; bus.INC = 0; bus.MOV = 0;
   endtask

   task automatic test_reset();
      #12;
      for (int i = 0; i < 11; i++) push(i, '0);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if (dut_val(e.idx) !== e.val) begin
            errors++;
            $display("FAIL reset %s: got %h expected %h", idx_name(e.idx), dut_val(e.idx), e.val);
         end
      end
      @(posedge CLK);
      #1 RST_N = 1'b1;
   endtask

   task automatic test_write();
      bus.WE = 1; bus.WADDR = 3'd5; bus.WDATA = 8'h3C;
      m_reg[5] = 8'h3C;
      push_model(1'b0);
      step();
      idle_inputs();
      while (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if (dut_val(e.idx) !== e.val) begin
            errors++;
            $display("FAIL write %s: got %h expected %h", idx_name(e.idx), dut_val(e.idx), e.val);
         end
      end
   endtask

   task automatic test_inc();
      logic [W-1:0] wd [4] = '{8'hFF, 8'h00, 8'h77, 8'h00};
      logic [2:0]   wa [4] = '{3'd2, 3'd2, 3'd6, 3'd2};
      logic         is_inc [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      for (int k = 0; k < 4; k++) begin
         bus.WADDR = wa[k]; bus.WDATA = wd[k];
         bus.WE = !is_inc[k]; bus.INC = is_inc[k];
         if (is_inc[k]) begin
            m_carry = (m_reg[wa[k]] == 8'hFF);
            m_reg[wa[k]] = m_reg[wa[k]] + 8'd1;
         end else begin
            m_reg[wa[k]] = wd[k];
         end
         push_model(1'b0);
         step();
         idle_inputs();
         while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (dut_val(e.idx) !== e.val) begin
               errors++;
               $display("FAIL inc step%0d %s: got %h expected %h", k, idx_name(e.idx), dut_val(e.idx), e.val);
            end
         end
      end
   endtask

   task automatic test_priority();
      bus.INC = 1; bus.WE = 1; bus.WADDR = 3'd5; bus.WDATA = 8'hEE;
      m_reg[5] = 8'h3D;
      m_carry  = 1'b0;
      push_model(1'b0);
      step();
      idle_inputs();
      while (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if (dut_val(e.idx) !== e.val) begin
            errors++;
            $display("FAIL priority %s: got %h expected %h", idx_name(e.idx), dut_val(e.idx), e.val);
         end
      end
   endtask

   task automatic test_mov();
      bus.WE = 1; bus.WADDR = 3'd0; bus.WDATA = 8'h11;
      m_reg[0] = 8'h11;
      step();
      // MOV with a competing WE: the WE is dropped.
      bus.MOV = 1; bus.SRC = 3'd0; bus.DST = 3'd7;
      bus.WE = 1; bus.WADDR = 3'd3; bus.WDATA = 8'h99;
      push_model(1'b1);
      step();
      idle_inputs();
      m_reg[7] = 8'h11;
      for (int p = 0; p < 2; p++) begin
         while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (dut_val(e.idx) !== e.val) begin
               errors++;
               $display("FAIL mov edge%0d %s: got %h expected %h", p + 1, idx_name(e.idx), dut_val(e.idx), e.val);
            end
         end
         if (p == 0) begin
            push_model(1'b0);
            step();
         end
      end
   endtask

   task automatic test_mov_ignore();
      bus.WE = 1; bus.WADDR = 3'd3; bus.WDATA = 8'h5A;
      m_reg[3] = 8'h5A;
      step();
      bus.WE = 0;
      bus.MOV = 1; bus.SRC = 3'd3; bus.DST = 3'd6;
      step();
      // In MOV_WR: everything presented here must be ignored.
      bus.MOV = 0; bus.WE = 1; bus.INC = 1;
      bus.WADDR = 3'd1; bus.WDATA = 8'hAA;
      bus.SRC = 3'd0; bus.DST = 3'd4;
      m_reg[6] = 8'h5A;
      push_model(1'b0);
      step();
      idle_inputs();
      while (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if (dut_val(e.idx) !== e.val) begin
            errors++;
            $display("FAIL mov_ignore %s: got %h expected %h", idx_name(e.idx), dut_val(e.idx), e.val);
         end
      end
   endtask

   task automatic test_mov_same();
      bus.MOV = 1; bus.SRC = 3'd5; bus.DST = 3'd5;
      push_model(1'b1);
      step();
      idle_inputs();
      for (int p = 0; p < 2; p++) begin
         while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (dut_val(e.idx) !== e.val) begin
               errors++;
               $display("FAIL mov_same edge%0d %s: got %h expected %h", p + 1, idx_name(e.idx), dut_val(e.idx), e.val);
            end
         end
         if (p == 0) begin
            push_model(1'b0);
            step();
         end
      end
   endtask

   task automatic test_rsel();
      for (int r = 0; r < 8; r++) begin
         bus.RSEL = 3'(r);
         if (r == 3) begin
            bus.MOV = 1; bus.SRC = 3'd0; bus.DST = 3'd1;
         end
         push(10, W'(r));
         push(9, (r == 3) ? 8'd1 : 8'd0);
         step();
         idle_inputs();
         while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (dut_val(e.idx) !== e.val) begin
               errors++;
               $display("FAIL rsel r=%0d %s: got %h expected %h", r, idx_name(e.idx), dut_val(e.idx), e.val);
            end
         end
      end
      m_reg[1] = m_reg[0];
      push_model(1'b0);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if (dut_val(e.idx) !== e.val) begin
            errors++;
            $display("FAIL rsel_mov %s: got %h expected %h", idx_name(e.idx), dut_val(e.idx), e.val);
         end
      end
   endtask

   task automatic test_reset_mid_mov();
      bus.RSEL = 3'd6;
      bus.MOV = 1; bus.SRC = 3'd0; bus.DST = 3'd2;
      step();
      idle_inputs();
      bus.RSEL = 3'd0;
      // Now in MOV_WR; reset asynchronously, away from any edge.
      RST_N = 1'b0;
      #2;
      for (int i = 0; i < 8; i++) m_reg[i] = '0;
      m_carry = 1'b0;
      push_model(1'b0);
      push(10, '0);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if (dut_val(e.idx) !== e.val) begin
            errors++;
            $display("FAIL reset_mid_mov %s: got %h expected %h", idx_name(e.idx), dut_val(e.idx), e.val);
         end
      end
      #1 RST_N = 1'b1;
      push_model(1'b0);
      step();
      step();
      while (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if (dut_val(e.idx) !== e.val) begin
            errors++;
            $display("FAIL after_release %s: got %h expected %h", idx_name(e.idx), dut_val(e.idx), e.val);
         end
      end
   endtask

   initial begin
      RST_N = 1'b0;
      bus.WE = 0; bus.INC = 0; bus.MOV = 0;
      bus.WADDR = '0; bus.WDATA = '0; bus.SRC = '0; bus.DST = '0; bus.RSEL = '0;
      for (int i = 0; i < 8; i++) m_reg[i] = '0;
      m_carry = 1'b0;
      test_reset();
      test_write();
      test_inc();
      test_priority();
      test_mov();
      test_mov_ignore();
      test_mov_same();
      test_rsel();
      test_reset_mid_mov();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
